// File: rtl/sram1rw1024x16_ctrl_pkg.sv
`default_nettype none
// Shared types and constants for the SRAM1RW1024x16 initiator and its testbench.
package sram1rw_ctrl_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int SRAM_WORDS  = 1024;
  localparam int SRAM_ADDR_W = 10;
  localparam int SRAM_DATA_W = 16;

  // Active-low macro strobes rest at this level.
  localparam logic STROBE_IDLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sram1rw1024x16_ctrl_resp_fifo.sv
`default_nettype none
// In-order response FIFO holding captured read data until the consumer takes it.
module sram_resp_fifo #(
  parameter int DATA_W     = 16,
  parameter int RESP_DEPTH = 2,
  parameter int CNT_W      = $clog2(RESP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head_data
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESP_DEPTH - 1);

  logic [DATA_W-1:0] mem [RESP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_pop;

  assign do_pop = pop && (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset, so present zero whenever nothing valid is held.
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/sram1rw1024x16_ctrl.sv
`default_nettype none
// Valid/ready initiator for one SRAM1RW1024x16 macro: zero-fill after reset,
// then single-cycle reads/writes with credit-limited, in-order read responses.
module sram1rw1024x16_ctrl
  import sram1rw_ctrl_pkg::*;
#(
  parameter int ADDR_W     = SRAM_ADDR_W,
  parameter int DATA_W     = SRAM_DATA_W,
  parameter int RESP_DEPTH = 2,
  parameter bit CLEAR_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  input  logic [DATA_W-1:0] sram_o,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb
);

  localparam int CNT_W  = $clog2(RESP_DEPTH + 1);
  localparam int CRED_W = CNT_W + 1;
  localparam logic [CRED_W-1:0] DEPTH_C = CRED_W'(RESP_DEPTH);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [ADDR_W-1:0] clr_ptr_next;
  logic              rd_inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CRED_W-1:0] credit_used;
  logic              run;
  logic              pop;
  logic              req_fire;
  logic              wr_fire;
  logic              rd_fire;

  assign run        = (state == RUN) && !reset;
  assign init_done  = run;
  assign resp_valid = (fifo_count != '0) && !reset;
  assign pop        = resp_valid && resp_ready;

  // Entries already owed to the FIFO, less the one leaving this cycle;
  // pop implies fifo_count > 0, so this never underflows.
  assign credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_inflight}
                     - {{CNT_W{1'b0}}, pop};

  assign req_ready = run && (credit_used < DEPTH_C);
  assign req_fire  = req_valid && req_ready;
  assign wr_fire   = req_fire && req_we;
  assign rd_fire   = req_fire && !req_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= CLEAR_EN ? CLEAR : RUN;
      clr_ptr     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      state       <= state_next;
      clr_ptr     <= clr_ptr_next;
      rd_inflight <= rd_fire;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    sram_csb     = STROBE_IDLE;
    sram_web     = STROBE_IDLE;
    sram_oeb     = STROBE_IDLE;
    sram_a       = '0;
    sram_i       = '0;
    if (!reset) begin
      case (state)
        CLEAR: begin
          sram_csb     = 1'b0;
          sram_web     = 1'b0;
          sram_a       = clr_ptr;
          clr_ptr_next = clr_ptr + ADDR_W'(1);
          if (clr_ptr == '1) begin
            state_next = RUN;
          end
        end
        RUN: begin
          if (wr_fire) begin
            sram_csb = 1'b0;
            sram_web = 1'b0;
            sram_a   = req_addr;
            sram_i   = req_wdata;
          end else if (rd_fire) begin
            sram_csb = 1'b0;
            sram_oeb = 1'b0;
            sram_a   = req_addr;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  // Macro output is valid the cycle after a read, so capture one edge later.
  sram_resp_fifo #(
    .DATA_W     (DATA_W),
    .RESP_DEPTH (RESP_DEPTH),
    .CNT_W      (CNT_W)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rd_inflight),
    .push_data (sram_o),
    .pop       (pop),
    .count     (fifo_count),
    .head_data (resp_rdata)
  );

endmodule
`default_nettype wire
